// File: rtl/delay_arb_pkg.sv
// Shared state encoding, default sizes and helpers for the delay arbiter.
// The optional count prescaler is enabled with DELAY_ARB_PRESCALE_EN.
package delay_arb_pkg;

  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefWidth = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StCount = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/delay_cnt.sv
// Loadable down-counter with enable and zero detect; it saturates at zero.
module delay_cnt
  import delay_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one delay counter among NREQ requesters.
// Define DELAY_ARB_PRESCALE_EN to step the counter once every PRESCALE clocks.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int unsigned NREQ     = DefNreq,
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dly,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt
);

  localparam int unsigned IdxW = $clog2(NREQ);

  arb_state_e      state_q;
  logic [NREQ-1:0] grant_q, done_q;
  logic            busy_q;
  logic [IdxW-1:0] ptr_q, win_q, win_next;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  int unsigned     scan_idx;
  logic            win_req, step, cnt_zero, cnt_load, cnt_clr;
  logic [WIDTH-1:0] win_dly;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    scan_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!pick_valid && req[IdxW'(scan_idx)]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'(scan_idx);
      end
    end
  end

  assign win_req  = req[win_q];
  assign win_dly  = dly[win_q*WIDTH +: WIDTH];
  assign win_next = IdxW'(rr_next(32'(win_q), NREQ));

  // Dropping the winner's request during LOAD or COUNT abandons the run.
  assign cnt_load = (state_q == StLoad) && win_req;
  assign cnt_clr  = ((state_q == StLoad) || (state_q == StCount)) && !win_req;

`ifdef DELAY_ARB_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PsW-1:0] presc_q;
  logic           presc_wrap;

  assign presc_wrap = (presc_q == PsW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (state_q == StLoad) begin
      presc_q <= '0;
    end else if (state_q == StCount) begin
      presc_q <= presc_wrap ? '0 : presc_q + PsW'(1);
    end
  end

  assign step = (state_q == StCount) && presc_wrap;
`else
  assign step = (state_q == StCount);
`endif

  delay_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .load_i    (cnt_load),
    .load_val_i(win_dly),
    .en_i      (step),
    .cnt_o     (cnt),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q <= StLoad;
            win_q   <= pick_idx;
            grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            busy_q  <= 1'b1;
          end
        end
        StLoad, StCount: begin
          if (!win_req) begin
            state_q <= StIdle;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= win_next;
          end else if (state_q == StLoad) begin
            state_q <= StCount;
          end else if (cnt_zero) begin
            state_q <= StDone;
            done_q  <= grant_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= win_next;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_done_owner:    assert property (@(posedge clk) disable iff (rst) (done & ~grant) == '0);
  a_busy_grant:    assert property (@(posedge clk) disable iff (rst) busy == (grant != '0));

endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: vector table, corner sequences and random traffic
// checked against a timeline model of each run.
module tb_delay_arbiter;

  localparam int N = 4;
  localparam int W = 16;
`ifdef DELAY_ARB_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] dly;
  logic [N-1:0] grant, done;
  logic         busy;
  logic [W-1:0] cnt;

  delay_arbiter #(
    .NREQ    (N),
    .WIDTH   (W),
    .PRESCALE(P)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .dly  (dly),
    .grant(grant),
    .done (done),
    .busy (busy),
    .cnt  (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N*W-1:0] dly;
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    logic         eb;
    logic [W-1:0] ec;
  } vec_t;

  vec_t vecs[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: owner of the current run (-1 when idle), cycle its request was
  // sampled, delay captured on the load cycle, and round-robin start point.
  int m_owner, m_ts, m_d, m_ptr;

  function automatic vec_t mk(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d,
                              input logic [N-1:0] g, input logic [N-1:0] dn, input logic b,
                              input int c);
    vec_t v;
    v.rst = r; v.req = q; v.dly = d; v.eg = g; v.ed = dn; v.eb = b; v.ec = W'(c);
    return v;
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    return 1'(v >> i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_check();
    logic [N-1:0] eg, ed;
    logic         eb;
    logic [W-1:0] ec;
    int e, l;
    eg = '0; ed = '0; eb = 1'b0; ec = '0;
    if (m_owner >= 0) begin
      e  = cyc - m_ts;
      l  = 3 + m_d * P;
      eg = N'(1) << m_owner;
      eb = 1'b1;
      if (e >= 2 && e < l) ec = W'(m_d - (e - 2) / P);
      if (e == l) ed = eg;
    end
    check("model_grant", 64'(grant), 64'(eg));
    check("model_done",  64'(done),  64'(ed));
    check("model_busy",  64'(busy),  64'(eb));
    check("model_cnt",   64'(cnt),   64'(ec));
  endtask

  task automatic model_step();
    int e, l, idx;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (m_owner < 0 && bit_of(req, idx)) m_owner = idx;
        end
        m_ts = cyc;
      end
    end else begin
      e = cyc - m_ts;
      l = 3 + m_d * P;
      if (e == l || !bit_of(req, m_owner)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (e == 1) begin
        m_d = int'(dly[m_owner*W +: W]);
      end
    end
  endtask

  task automatic tick();
    model_check();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*W-1:0] d5, dx, d1z, d3;
    logic [N-1:0]   exp_order [5];
    int             k;
    logic [N-1:0]   prev_g;
    logic           found;

    rst = 1'b1; req = '0; dly = '0;
    m_owner = -1; m_ptr = 0; m_ts = 0; m_d = 0;
    @(posedge clk);
    #1;

    d5  = 64'h0000_0000_0000_0005;
    dx  = 64'h1234_5678_9ABC_FFFF;
    d1z = 64'h1234_5678_0000_9ABC;
    d3  = 64'h0000_0000_0000_0003;

    vecs.push_back(mk(1'b1, 4'h0, '0, 4'h0, 4'h0, 1'b0, 0));
`ifdef DELAY_ARB_PRESCALE_EN
    vecs.push_back(mk(1'b0, 4'h1, d3, 4'h1, 4'h0, 1'b1, 0));
    for (int e = 2; e <= 14; e++) begin
      vecs.push_back(mk(1'b0, 4'h1, (e == 2) ? d3 : dx, 4'h1, 4'h0, 1'b1, 3 - (e - 2) / 4));
    end
    vecs.push_back(mk(1'b0, 4'h1, dx, 4'h1, 4'h1, 1'b1, 0));
    vecs.push_back(mk(1'b0, 4'h0, dx, 4'h0, 4'h0, 1'b0, 0));
`else
    vecs.push_back(mk(1'b0, 4'h1, d5, 4'h1, 4'h0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 4'h1, d5, 4'h1, 4'h0, 1'b1, 5));
    for (int c = 4; c >= 0; c--) begin
      vecs.push_back(mk(1'b0, 4'h1, dx, 4'h1, 4'h0, 1'b1, c));
    end
    vecs.push_back(mk(1'b0, 4'h1, dx, 4'h1, 4'h1, 1'b1, 0));
    vecs.push_back(mk(1'b0, 4'h0, dx, 4'h0, 4'h0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 4'h2, d1z, 4'h2, 4'h0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 4'h2, d1z, 4'h2, 4'h0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 4'h2, d1z, 4'h2, 4'h2, 1'b1, 0));
    vecs.push_back(mk(1'b0, 4'h0, d1z, 4'h0, 4'h0, 1'b0, 0));
`endif

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; dly = vecs[i].dly;
      tick();
      check($sformatf("tbl%0d_grant", i), 64'(grant), 64'(vecs[i].eg));
      check($sformatf("tbl%0d_done", i),  64'(done),  64'(vecs[i].ed));
      check($sformatf("tbl%0d_busy", i),  64'(busy),  64'(vecs[i].eb));
      check($sformatf("tbl%0d_cnt", i),   64'(cnt),   64'(vecs[i].ec));
    end
    rst = 1'b0;

    // All four requesting: grants rotate and each done lands on its owner.
    exp_order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    do_reset();
    req = 4'hF;
    dly = 64'h0002_0002_0002_0002;
    k = 0;
    for (int i = 0; i < 300 && k < 5; i++) begin
      prev_g = grant;
      tick();
      if (grant != '0 && prev_g == '0) begin
        check("rr_order", 64'(grant), 64'(exp_order[k]));
        k++;
      end
      if (done != '0) check("rr_done", 64'(done), 64'(exp_order[k-1]));
    end
    check("rr_count", 64'(k), 64'(5));

    // Requester 0 withdraws mid-count; requester 1 is served next.
    do_reset();
    req = 4'h3;
    dly = 64'h0000_0000_0003_000A;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      check("cancel_nodone", 64'(done), 64'(0));
      if (cnt == W'(4) && grant == 4'h1) found = 1'b1;
    end
    check("cancel_reach4", 64'(found), 64'(1));
    req = 4'h2;
    tick();
    check("cancel_idle_grant", 64'(grant), 64'(0));
    check("cancel_idle_busy",  64'(busy),  64'(0));
    check("cancel_idle_done",  64'(done),  64'(0));
    tick();
    check("cancel_next_grant", 64'(grant), 64'(4'h2));

    // Reset in the middle of a count.
    do_reset();
    req = 4'h1;
    dly = 64'h0000_0000_0000_000A;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (cnt == W'(7)) found = 1'b1;
    end
    check("rst_reach7", 64'(found), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_done",  64'(done),  64'(0));
    check("rst_busy",  64'(busy),  64'(0));
    check("rst_cnt",   64'(cnt),   64'(0));
    req = 4'h4;
    tick();
    check("rst_regrant", 64'(grant), 64'(4'h4));

    // Random traffic: sticky requests, delays reshuffled every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 11) == 0) req = N'($urandom);
      for (int s = 0; s < N; s++) dly[s*W +: W] = W'($urandom_range(0, 6));
      tick();
    end
    rst = 1'b0;
    req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
